// File: rtl/pc_flag_unit_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_flag_unit_pkg                                                         |
// | Shared state encoding, default widths and helpers for pc_flag_unit.      |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package pc_flag_unit_pkg;

    localparam int PC_W_DEF      = 10;
    localparam int LUT_IDX_W_DEF = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } pc_state_e;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pc_flag_unit_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_flag_unit_if                                                          |
// | Run-control, branch and status bus between the core/top and the PC unit.|
// | Optional CYCLES output present when PC_CYCLE_COUNT_EN is defined.        |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
interface pc_flag_unit_if
    import pc_flag_unit_pkg::*;
#(
    parameter int PC_W      = PC_W_DEF,
    parameter int LUT_IDX_W = LUT_IDX_W_DEF
);
    logic                 start;
    logic                 stall;
    logic                 halt_req;
    logic                 branch_en;
    logic [LUT_IDX_W-1:0] branch_idx;
    logic                 flag_we;
    logic                 flag_d;
    logic                 ovf_we;
    logic                 ovf_d;
    logic [PC_W-1:0]      pc;
    logic                 flag;
    logic                 overflow;
    logic                 running;
    logic                 done;
`ifdef PC_CYCLE_COUNT_EN
    logic [15:0]          cycles;
`endif

    modport master (
        output start, stall, halt_req, branch_en, branch_idx,
        output flag_we, flag_d, ovf_we, ovf_d,
`ifdef PC_CYCLE_COUNT_EN
        input  cycles,
`endif
        input  pc, flag, overflow, running, done
    );

    modport slave (
        input  start, stall, halt_req, branch_en, branch_idx,
        input  flag_we, flag_d, ovf_we, ovf_d,
`ifdef PC_CYCLE_COUNT_EN
        output cycles,
`endif
        output pc, flag, overflow, running, done
    );

endinterface
`default_nettype wire

// File: rtl/pc_flag_unit_branch_lut.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_flag_unit_branch_lut                                                  |
// | Combinational branch-target ROM; edit the table here to change programs. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pc_flag_unit_branch_lut
    import pc_flag_unit_pkg::*;
#(
    parameter int              PC_W       = PC_W_DEF,
    parameter int              LUT_IDX_W  = LUT_IDX_W_DEF,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic [LUT_IDX_W-1:0] idx,
    output logic [PC_W-1:0]      target
);

    always_comb begin
        target = START_ADDR;
        case (idx)
            LUT_IDX_W'(3): target = PC_W'(10'h040);
            LUT_IDX_W'(5): target = PC_W'(10'h3FF);
            LUT_IDX_W'(7): target = PC_W'(10'h00C);
            LUT_IDX_W'(9): target = PC_W'(10'h025);
            // unprogrammed slots fall back to the restart address
            default:       target = START_ADDR;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/pc_flag_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pc_flag_unit                                                             |
// | PC and FLAG/OVERFLOW status stage with IDLE/RUN/HALT run control.        |
// | Optional cycle counter enabled by macro PC_CYCLE_COUNT_EN.               |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module pc_flag_unit
    import pc_flag_unit_pkg::*;
#(
    parameter int              PC_W       = PC_W_DEF,
    parameter int              LUT_IDX_W  = LUT_IDX_W_DEF,
    parameter logic [PC_W-1:0] START_ADDR = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    pc_flag_unit_if.slave bus
);

    pc_state_e       state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            flag_q, flag_d;
    logic            ovfl_q, ovfl_d;
    logic [PC_W-1:0] lut_target;
`ifdef PC_CYCLE_COUNT_EN
    logic [15:0]     cyc_q, cyc_d;
`endif

    pc_flag_unit_branch_lut #(
        .PC_W       (PC_W),
        .LUT_IDX_W  (LUT_IDX_W),
        .START_ADDR (START_ADDR)
    ) u_branch_lut (
        .idx    (bus.branch_idx),
        .target (lut_target)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        flag_d  = flag_q;
        ovfl_d  = ovfl_q;
`ifdef PC_CYCLE_COUNT_EN
        cyc_d   = cyc_q;
`endif
        case (state_q)
            IDLE, HALT: begin
                if (bus.start) begin
                    state_d = RUN;
                    pc_d    = START_ADDR;
                    flag_d  = 1'b0;
                    ovfl_d  = 1'b0;
`ifdef PC_CYCLE_COUNT_EN
                    cyc_d   = 16'd0;
`endif
                end
            end
            RUN: begin
                // START is deliberately not decoded here: a restart needs HALT first
                if (!bus.stall) begin
                    if (bus.flag_we) flag_d = bus.flag_d;
                    if (bus.ovf_we)  ovfl_d = bus.ovf_d;
`ifdef PC_CYCLE_COUNT_EN
                    cyc_d = sat_inc16(cyc_q);
`endif
                    if (bus.halt_req) begin
                        state_d = HALT;
                    end else if (bus.branch_en) begin
                        pc_d = lut_target;
                    end else begin
                        pc_d = pc_q + PC_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= START_ADDR;
            flag_q  <= 1'b0;
            ovfl_q  <= 1'b0;
`ifdef PC_CYCLE_COUNT_EN
            cyc_q   <= 16'd0;
`endif
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            flag_q  <= flag_d;
            ovfl_q  <= ovfl_d;
`ifdef PC_CYCLE_COUNT_EN
            cyc_q   <= cyc_d;
`endif
        end
    end

    assign bus.pc       = pc_q;
    assign bus.flag     = flag_q;
    assign bus.overflow = ovfl_q;
    assign bus.running  = (state_q == RUN);
    assign bus.done     = (state_q == HALT);
`ifdef PC_CYCLE_COUNT_EN
    assign bus.cycles   = cyc_q;
`endif

endmodule
`default_nettype wire

// File: doc/pc_flag_unit.md
Name: pc_flag_unit

Overview:
Program-counter and status-register stage for the single-cycle core.
- Holds PC, FLAG and OVERFLOW state; feeds FLAG/OVERFLOW back into the ALU's FLAG_IN/OVERFLOW_IN.
- Consumes the ALU's FLAG_OUT, OVERFLOW_OUT and FLAG_BRANCH_EN to select the next PC: sequential, or branch target from a lookup table.
- Run control via START/HALT handshake with the testbench/top.

Parameters:
PC_W, 10, program counter width in bits.
LUT_IDX_W, 4, branch-target LUT index width (2**LUT_IDX_W entries).
START_ADDR, 0, PC value loaded on reset and on START.

Ports:
CLK  input  1  system clock, all state on rising edge.
RESET_N  input  1  asynchronous, active-low reset.
START  input  1  one-cycle pulse; begin execution at START_ADDR.
STALL  input  1  freeze PC and status registers this cycle.
HALT_REQ  input  1  decoded halt instruction at current PC.
BRANCH_EN  input  1  from ALU FLAG_BRANCH_EN.
BRANCH_IDX  input  LUT_IDX_W  branch-target LUT index from instruction field.
FLAG_WE  input  1  write FLAG from FLAG_D this cycle.
FLAG_D  input  1  from ALU FLAG_OUT.
OVF_WE  input  1  write OVERFLOW from OVF_D this cycle.
OVF_D  input  1  from ALU OVERFLOW_OUT.
PC  output  PC_W  current instruction address.
FLAG  output  1  registered flag, to ALU FLAG_IN.
OVERFLOW  output  1  registered carry/shift bit, to ALU OVERFLOW_IN.
RUNNING  output  1  high while in RUN.
DONE  output  1  high while in HALT.

Behaviour:
- Reset (RESET_N low, async): state=IDLE, PC=START_ADDR, FLAG=0, OVERFLOW=0, RUNNING=0, DONE=0. Reset mid-run aborts immediately; no partial update survives.
- States: IDLE, RUN, HALT. RUNNING=(state==RUN), DONE=(state==HALT); both registered-state decodes, no combinational path from inputs.
- IDLE: START -> RUN, PC<=START_ADDR, FLAG<=0, OVERFLOW<=0. Other inputs ignored.
- RUN, STALL=1: PC, FLAG, OVERFLOW, state all hold; HALT_REQ, BRANCH_EN and WEs are ignored.
- RUN, STALL=0, priority HALT_REQ > BRANCH_EN > sequential:
  - HALT_REQ=1: -> HALT, PC holds (points at halt instruction). Status writes this cycle are still performed.
  - BRANCH_EN=1: PC<=lut[BRANCH_IDX] (absolute, PC_W bits).
  - else: PC<=PC+1, modulo 2**PC_W (max value wraps to 0, no error).
- FLAG_WE/OVF_WE independent of PC update; each writes its D value at the clock edge when state==RUN and STALL=0. Simultaneous FLAG_WE and OVF_WE both take effect.
- START while RUN: ignored. START in HALT: -> RUN, same reload as from IDLE (restart). START and HALT_REQ same cycle in RUN: halt taken, START ignored.
- Latency: one cycle from BRANCH_EN/HALT_REQ sample to new PC/DONE. FLAG written at edge N is visible on FLAG (and ALU FLAG_IN) in cycle N+1.
- LUT: 2**LUT_IDX_W constant entries; unprogrammed indices return START_ADDR.

Optional Feature:
PC_CYCLE_COUNT_EN: when defined, adds output CYCLES [15:0].
- Reset/START clear it to 0.
- Increments each RUN cycle with STALL=0, saturating at 16'hFFFF.
- Holds in HALT.
When undefined, the port and counter are absent and the rest of the behaviour is identical.

Decomposition:
Shared definitions package:
- enum pc_state_e {IDLE, RUN, HALT}.
- PC_W and LUT_IDX_W default constants.
One sub-module, branch_lut: combinational ROM, BRANCH_IDX -> target PC. The table contents live there, so programs change only that file.

Test Plan:
- Reset then START: PC=0, RUNNING=1 next cycle; 5 non-branch cycles -> PC=5.
- Branch: lut[3]=10'h040, BRANCH_EN=1, BRANCH_IDX=3 at PC=7 -> PC=0x040 next cycle. With BRANCH_EN=1 and STALL=1 -> PC stays 7.
- Wrap: PC=10'h3FF, sequential step -> PC=0.
- Halt priority: HALT_REQ=1 and BRANCH_EN=1 at PC=12 -> DONE=1, PC=12 held. Later START -> PC=0, FLAG=0, OVERFLOW=0, RUNNING=1.
- Status: FLAG_WE=1, FLAG_D=1, OVF_WE=1, OVF_D=1 -> next cycle FLAG=1, OVERFLOW=1. Same writes with STALL=1 -> unchanged.
- Async reset mid-run at PC=0x025 with FLAG=1 -> PC=0, FLAG=0, state IDLE before the next CLK edge. With PC_CYCLE_COUNT_EN: CYCLES=0.
